// File: rtl/moving_avg_stim_gen_pkg.sv
// Shared types and constants for the moving-average stimulus generator.
package moving_avg_stim_gen_pkg;

  localparam int DATA_W     = 10;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    MODE_IMPULSE = 2'b00,
    MODE_STEP    = 2'b01,
    MODE_RAMP    = 2'b10,
    MODE_SQUARE  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Strobe spacing below MIN_PERIOD collapses to MIN_PERIOD.
  function automatic logic [3:0] eff_period(input logic [3:0] p);
    if (p < 4'(MIN_PERIOD)) begin
      return 4'(MIN_PERIOD);
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/moving_avg_stim_gen_stim_wave_calc.sv
// Sample value generator: combinational waveform select plus the wrapping ramp accumulator.
module stim_wave_calc
  import moving_avg_stim_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  mode_e             mode,
  input  logic [5:0]        k,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [5:0]        imp_index,
  input  logic              acc_load,
  input  logic              acc_step,
  output logic [DATA_W-1:0] sample
);

  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] ramp_s;

  // Ramp accumulator holds k*amplitude for the next sample to be emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (acc_load) begin
      acc_r <= amplitude;
    end else if (acc_step) begin
      acc_r <= acc_r + amplitude;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Sample index 0 of a fresh sequence is emitted while the accumulator is still being loaded.
  always_comb begin
    if (acc_load) begin
      ramp_s = '0;
    end else begin
      ramp_s = acc_r;
    end
  end

  // Waveform select for sample index k.
  always_comb begin
    sample = '0;
    case (mode)
      MODE_IMPULSE: begin
        if (k == imp_index) begin
          sample = amplitude;
        end else begin
          sample = '0;
        end
      end
      MODE_STEP:    sample = amplitude;
      MODE_RAMP:    sample = ramp_s;
      MODE_SQUARE: begin
        if (k[2] == 1'b0) begin
          sample = amplitude;
        end else begin
          sample = '0;
        end
      end
      default:      sample = '0;
    endcase
  end

endmodule

// File: rtl/moving_avg_stim_gen.sv
// Stimulus generator top: sequence FSM, strobe spacing and sample counters, registered outputs.
module moving_avg_stim_gen
  import moving_avg_stim_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [3:0]        period,
  input  logic [5:0]        length,
  input  logic [5:0]        imp_index,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              busy,
  output logic              done
);

  state_e            state_r;
  mode_e             mode_r;
  logic [DATA_W-1:0] amp_r;
  logic [3:0]        period_r;
  logic [5:0]        len_r;
  logic [5:0]        imp_r;
  logic [5:0]        k_r;
  logic [3:0]        space_r;

  logic              start_ok_s;
  logic              due_s;
  logic              acc_load_s;
  mode_e             mode_s;
  logic [DATA_W-1:0] amp_s;
  logic [5:0]        k_s;
  logic [5:0]        imp_s;
  logic [DATA_W-1:0] sample_s;

  // space_r counts enabled clocks since the last strobe; it holds while ena is low.
  always_comb begin
    start_ok_s = ena && start && (state_r == ST_IDLE);
    due_s      = ena && (state_r == ST_RUN) && (space_r >= period_r);
    acc_load_s = start_ok_s && (length != 6'd0);
  end

  // Sample 0 is produced from the live inputs in the latch cycle, later samples from the latched copy.
  always_comb begin
    if (state_r == ST_IDLE) begin
      mode_s = mode_e'(mode);
      amp_s  = amplitude;
      k_s    = 6'd0;
      imp_s  = imp_index;
    end else begin
      mode_s = mode_r;
      amp_s  = amp_r;
      k_s    = k_r;
      imp_s  = imp_r;
    end
  end

  stim_wave_calc u_wave (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode_s),
    .k         (k_s),
    .amplitude (amp_s),
    .imp_index (imp_s),
    .acc_load  (acc_load_s),
    .acc_step  (due_s),
    .sample    (sample_s)
  );

  // Sequence FSM with counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_IMPULSE;
      amp_r      <= '0;
      period_r   <= 4'd0;
      len_r      <= 6'd0;
      imp_r      <= 6'd0;
      k_r        <= 6'd0;
      space_r    <= 4'd0;
      data_out   <= '0;
      strobe_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (!ena) begin
      strobe_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      strobe_out <= 1'b0;
      done       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r   <= mode_e'(mode);
            amp_r    <= amplitude;
            period_r <= eff_period(period);
            len_r    <= length;
            imp_r    <= imp_index;
            busy     <= 1'b1;
            if (length == 6'd0) begin
              k_r     <= 6'd0;
              space_r <= 4'd0;
              state_r <= ST_FINISH;
            end else begin
              strobe_out <= 1'b1;
              data_out   <= sample_s;
              k_r        <= 6'd1;
              space_r    <= 4'd1;
              state_r    <= (length == 6'd1) ? ST_FINISH : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (due_s) begin
            strobe_out <= 1'b1;
            data_out   <= sample_s;
            k_r        <= k_r + 6'd1;
            space_r    <= 4'd1;
            if ((k_r + 6'd1) == len_r) begin
              state_r <= ST_FINISH;
            end
          end else begin
            space_r <= space_r + 4'd1;
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          k_r     <= 6'd0;
          space_r <= 4'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moving_avg_stim_gen.sv
// Scoreboard bench: a sequence-level model predicts every strobe and done pulse with its clock number.
module tb_moving_avg_stim_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        start;
  logic [1:0]  mode;
  logic [9:0]  amplitude;
  logic [3:0]  period;
  logic [5:0]  length;
  logic [5:0]  imp_index;
  logic [9:0]  data_out;
  logic        strobe_out;
  logic        busy;
  logic        done;

  typedef struct {
    bit is_done;
    int data;
    int cyc;
  } ev_t;

  ev_t sb_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  gap_lo = 0;
  int  gap_hi = 0;
  int  exp_hold = 0;

  moving_avg_stim_gen dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .mode       (mode),
    .amplitude  (amplitude),
    .period     (period),
    .length     (length),
    .imp_index  (imp_index),
    .data_out   (data_out),
    .strobe_out (strobe_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ena_at(int e);
    return !(e >= gap_lo && e < gap_hi);
  endfunction

  function automatic int next_en(int e);
    int x = e + 1;
    while (!ena_at(x)) x++;
    return x;
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (clock %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ena = ena_at(cyc + 1);
  endtask

  // Expected events: sample k appears on the P-th enabled clock after sample k-1, done on the next enabled clock.
  task automatic plan(int m, int amp, int per, int len, int imp, int s_edge);
    int  p = (per < 2) ? 2 : per;
    int  e = s_edge;
    int  v;
    ev_t ev;
    for (int k = 0; k < len; k++) begin
      if (k > 0) for (int j = 0; j < p; j++) e = next_en(e);
      case (m)
        0:       v = (k == imp) ? amp : 0;
        1:       v = amp;
        2:       v = (k * amp) % 1024;
        default: v = (((k / 4) % 2) == 0) ? amp : 0;
      endcase
      ev.is_done = 1'b0; ev.data = v; ev.cyc = e;
      sb_q.push_back(ev);
    end
    ev.is_done = 1'b1; ev.data = 0; ev.cyc = next_en(e);
    sb_q.push_back(ev);
  endtask

  task automatic launch(int m, int amp, int per, int len, int imp, int gap_off, int gap_len,
                        output int s_edge);
    tick();
    s_edge = cyc + 1;
    if (gap_len > 0) begin
      gap_lo = s_edge + gap_off;
      gap_hi = gap_lo + gap_len;
    end else begin
      gap_lo = 0;
      gap_hi = 0;
    end
    ena       = ena_at(s_edge);
    start     = 1'b1;
    mode      = 2'(m);
    amplitude = 10'(amp);
    period    = 4'(per);
    length    = 6'(len);
    imp_index = 6'(imp);
    plan(m, amp, per, len, imp, s_edge);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_seq(int m, int amp, int per, int len, int imp, int gap_off, int gap_len,
                         int restart_at);
    int s_edge;
    int budget = 0;
    launch(m, amp, per, len, imp, gap_off, gap_len, s_edge);
    while (sb_q.size() > 0 && budget < 1200) begin
      mode      = 2'($urandom);
      amplitude = 10'($urandom);
      period    = 4'($urandom);
      length    = 6'($urandom);
      imp_index = 6'($urandom);
      start     = (budget == restart_at) ? 1'b1 : 1'b0;
      tick();
      budget++;
    end
    start = 1'b0;
    if (sb_q.size() > 0) begin
      check("seq_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    repeat (3) tick();
    check("busy_idle", busy, 0);
  endtask

  task automatic reset_mid();
    int s_edge;
    launch(2, 77, 3, 20, 0, 0, 0, s_edge);
    while (cyc < s_edge + 7 * 3) tick();
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_data", data_out, 0);
    check("rst_mid_strobe", strobe_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_pending", sb_q.size(), 13);
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("rst_mid_idle_busy", busy, 0);
  endtask

  // Monitor: every strobe or done is matched against the head of the scoreboard.
  initial begin : monitor
    ev_t ev;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_hold = 0;
      end else if (strobe_out || done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", cyc, -1);
        end else begin
          ev = sb_q.pop_front();
          check(ev.is_done ? "done_clock" : "strobe_clock", cyc, ev.cyc);
          check("done_flag", done, ev.is_done);
          check("strobe_flag", strobe_out, !ev.is_done);
          if (!ev.is_done) begin
            check("strobe_data", data_out, ev.data);
            check("busy_on_strobe", busy, 1);
            exp_hold = ev.data;
          end else begin
            check("busy_at_done", busy, 0);
          end
        end
      end else begin
        check("data_hold", data_out, exp_hold);
      end
    end
  end

  initial begin
    int m, amp, per, len, imp, goff, glen, rs;
    rst = 1'b1; ena = 1'b0; start = 1'b0; mode = 2'd0; amplitude = 10'd0;
    period = 4'd0; length = 6'd0; imp_index = 6'd0;
    repeat (2) @(negedge clk);
    check("reset_data", data_out, 0);
    check("reset_strobe", strobe_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    repeat (3) tick();

    run_seq(0, 1023, 2, 50, 11, 0, 0, -1);
    run_seq(2, 300, 3, 6, 0, 0, 0, 2);
    run_seq(1, 555, 5, 0, 0, 0, 0, -1);
    run_seq(1, 99, 0, 4, 0, 0, 0, -1);
    run_seq(3, 200, 1, 9, 0, 0, 0, -1);
    run_seq(0, 800, 4, 20, 40, 0, 0, -1);
    run_seq(3, 512, 4, 12, 0, 9, 5, -1);
    run_seq(0, 17, 2, 1, 0, 0, 0, -1);
    reset_mid();
    run_seq(2, 1000, 2, 8, 0, 3, 2, 3);

    for (int i = 0; i < 12; i++) begin
      m    = int'($urandom_range(3, 0));
      amp  = int'($urandom_range(1023, 0));
      per  = int'($urandom_range(15, 0));
      len  = int'($urandom_range(20, 0));
      imp  = int'($urandom_range(25, 0));
      goff = int'($urandom_range(20, 1));
      glen = int'($urandom_range(6, 0));
      rs   = (len >= 3) ? int'($urandom_range(4, 0)) : -1;
      run_seq(m, amp, per, len, imp, goff, glen, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
